butterfly_r2_twiddle: RTL and testbench

- Radix-2 DIF butterfly stage with twiddle multiply, directly downstream of the sample-pair demultiplexor in the sequential FFT datapath.
- Consumes one complex pair (x1, x2) plus one aligned twiddle per valid cycle.
- Produces X = x1 + x2 and Y = (x1 - x2)·W, with round-half-up, optional divide-by-2 scaling and saturation.
- Tracks pair count within a frame to flag the last output pair.

---
 rtl/butterfly_r2_twiddle.sv | 153 +++++++++++++++
 tb/tb_butterfly_r2_twiddle.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_r2_twiddle.sv
// Radix-2 DIF butterfly with twiddle multiply: X = x1 + x2, Y = (x1 - x2) * W.
// Fixed 3-cycle latency, no backpressure, frame-position tracking via out_last.
module butterfly_r2_twiddle #(
  parameter int bit_width      = 16,
  parameter int word_length_tw = 14,
  parameter int fft_length     = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [bit_width-1:0]      Re_i1,
  input  logic signed [bit_width-1:0]      Im_i1,
  input  logic signed [bit_width-1:0]      Re_i2,
  input  logic signed [bit_width-1:0]      Im_i2,
  input  logic signed [word_length_tw-1:0] cos_data,
  input  logic signed [word_length_tw-1:0] sin_data,
  input  logic                             in_valid,
  input  logic                             scale_en,
  input  logic                             clr_sat,
  output logic signed [bit_width-1:0]      Re_X,
  output logic signed [bit_width-1:0]      Im_X,
  output logic signed [bit_width-1:0]      Re_Y,
  output logic signed [bit_width-1:0]      Im_Y,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             sat_flag
);

  // Handshake: in_valid qualifies one pair + twiddle per cycle; out_valid is a
  // single-cycle strobe three edges later. There is no ready; the block never stalls.

  localparam int SW   = bit_width + 1;
  localparam int PW   = bit_width + word_length_tw + 1;
  localparam int YW   = PW + 1 - (word_length_tw - 2);
  localparam int CW   = bit_width + 5;
  localparam int NP   = fft_length / 2;
  localparam int CNTW = (NP > 1) ? $clog2(NP) : 1;

  localparam logic signed [PW:0]     RND  = (PW+1)'(1) << (word_length_tw - 3);
  localparam logic signed [CW-1:0]   ONE  = CW'(1);
  localparam logic signed [CW-1:0]   SMAX = CW'((2 ** (bit_width - 1)) - 1);
  localparam logic signed [CW-1:0]   SMIN = -SMAX - ONE;
  localparam logic [CNTW-1:0]        LAST = CNTW'(NP - 1);

  // Stage 1 registers
  logic signed [SW-1:0]             r_sum1_re, r_sum1_im, r_diff_re, r_diff_im;
  logic signed [word_length_tw-1:0] r_cos, r_sin;
  logic                             r_v1, r_sc1;
  // Stage 2 registers
  logic signed [PW-1:0]             r_p_rc, r_p_is, r_p_rs, r_p_ic;
  logic signed [SW-1:0]             r_sum2_re, r_sum2_im;
  logic                             r_v2, r_sc2;
  // Stage 3 registers
  logic signed [YW-1:0]             r_y_re, r_y_im;
  logic signed [SW-1:0]             r_sum3_re, r_sum3_im;
  logic                             r_v3, r_sc3;
  logic [CNTW-1:0]                  r_cnt;

  logic signed [SW-1:0]             w_sum_re, w_sum_im, w_diff_re, w_diff_im;
  logic signed [PW:0]               w_y_re_full, w_y_im_full;
  logic signed [CW-1:0]             w_xr, w_xi, w_yr, w_yi;
  logic                             w_any_clip;

  assign w_sum_re  = SW'(Re_i1) + SW'(Re_i2);
  assign w_sum_im  = SW'(Im_i1) + SW'(Im_i2);
  assign w_diff_re = SW'(Re_i1) - SW'(Re_i2);
  assign w_diff_im = SW'(Im_i1) - SW'(Im_i2);

  assign w_y_re_full = (PW+1)'(r_p_rc) - (PW+1)'(r_p_is) + RND;
  assign w_y_im_full = (PW+1)'(r_p_rs) + (PW+1)'(r_p_ic) + RND;

  function automatic logic signed [CW-1:0] scl(input logic signed [CW-1:0] v, input logic en);
    return en ? ((v + ONE) >>> 1) : v;
  endfunction

  function automatic logic clipped(input logic signed [CW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  function automatic logic signed [bit_width-1:0] sat(input logic signed [CW-1:0] v);
    if (v > SMAX)      return SMAX[bit_width-1:0];
    else if (v < SMIN) return SMIN[bit_width-1:0];
    else               return v[bit_width-1:0];
  endfunction

  assign w_xr = scl(CW'(r_sum3_re), r_sc3);
  assign w_xi = scl(CW'(r_sum3_im), r_sc3);
  assign w_yr = scl(CW'(r_y_re), r_sc3);
  assign w_yi = scl(CW'(r_y_im), r_sc3);
  assign w_any_clip = clipped(w_xr) | clipped(w_xi) | clipped(w_yr) | clipped(w_yi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0; r_sc1 <= 1'b0;
      r_sum1_re <= '0; r_sum1_im <= '0; r_diff_re <= '0; r_diff_im <= '0;
      r_cos <= '0; r_sin <= '0;
      r_v2 <= 1'b0; r_sc2 <= 1'b0;
      r_p_rc <= '0; r_p_is <= '0; r_p_rs <= '0; r_p_ic <= '0;
      r_sum2_re <= '0; r_sum2_im <= '0;
      r_v3 <= 1'b0; r_sc3 <= 1'b0;
      r_y_re <= '0; r_y_im <= '0; r_sum3_re <= '0; r_sum3_im <= '0;
    end else begin
      r_v1      <= in_valid;
      r_sc1     <= scale_en;
      r_sum1_re <= w_sum_re;
      r_sum1_im <= w_sum_im;
      r_diff_re <= w_diff_re;
      r_diff_im <= w_diff_im;
      r_cos     <= cos_data;
      r_sin     <= sin_data;

      r_v2      <= r_v1;
      r_sc2     <= r_sc1;
      r_p_rc    <= PW'(r_diff_re) * PW'(r_cos);
      r_p_is    <= PW'(r_diff_im) * PW'(r_sin);
      r_p_rs    <= PW'(r_diff_re) * PW'(r_sin);
      r_p_ic    <= PW'(r_diff_im) * PW'(r_cos);
      r_sum2_re <= r_sum1_re;
      r_sum2_im <= r_sum1_im;

      // Round half up back to data scale: twiddle 1.0 sits at 2^(word_length_tw-2)
      r_v3      <= r_v2;
      r_sc3     <= r_sc2;
      r_y_re    <= YW'(w_y_re_full >>> (word_length_tw - 2));
      r_y_im    <= YW'(w_y_im_full >>> (word_length_tw - 2));
      r_sum3_re <= r_sum2_re;
      r_sum3_im <= r_sum2_im;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Re_X <= '0; Im_X <= '0; Re_Y <= '0; Im_Y <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      out_valid <= r_v3;
      out_last  <= r_v3 && (r_cnt == LAST);
      if (r_v3) begin
        Re_X  <= sat(w_xr);
        Im_X  <= sat(w_xi);
        Re_Y  <= sat(w_yr);
        Im_Y  <= sat(w_yi);
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNTW'(1);
      end
      // A new clip takes priority over a simultaneous clear
      if (r_v3 && w_any_clip) sat_flag <= 1'b1;
      else if (clr_sat)       sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_r2_twiddle.sv
// Bench for butterfly_r2_twiddle: arithmetic reference model, expected queue with
// due cycles, directed test-plan cases, randomized traffic and reset-in-flight.
module tb_butterfly_r2_twiddle;

  localparam int BW = 16;
  localparam int TW = 14;
  localparam int FL = 8;
  localparam int NP = FL / 2;
  localparam int EW = 32 + 65;

  logic clk, rst;
  logic signed [BW-1:0] Re_i1, Im_i1, Re_i2, Im_i2;
  logic signed [TW-1:0] cos_data, sin_data;
  logic in_valid, scale_en, clr_sat;
  logic signed [BW-1:0] Re_X, Im_X, Re_Y, Im_Y;
  logic out_valid, out_last, sat_flag;

  butterfly_r2_twiddle #(.bit_width(BW), .word_length_tw(TW), .fft_length(FL)) dut (
    .clk(clk), .rst(rst),
    .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
    .cos_data(cos_data), .sin_data(sin_data),
    .in_valid(in_valid), .scale_en(scale_en), .clr_sat(clr_sat),
    .Re_X(Re_X), .Im_X(Im_X), .Re_Y(Re_Y), .Im_Y(Im_Y),
    .out_valid(out_valid), .out_last(out_last), .sat_flag(sat_flag)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic [63:0]   last_data;
  logic          exp_v, exp_sat, clr_q;
  int            cyc, m_cnt;
  int            n_cmp, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, floor-based rounding, clip to the signed range.
  function automatic logic [64:0] model(input int a_re, a_im, b_re, b_im, c, s, input bit sc);
    longint v[4];
    longint dr, di;
    logic [15:0] o[4];
    bit clip;
    clip = 1'b0;
    dr = longint'(a_re) - b_re;
    di = longint'(a_im) - b_im;
    v[0] = longint'(a_re) + b_re;
    v[1] = longint'(a_im) + b_im;
    v[2] = (dr * c - di * s + 2048) >>> 12;
    v[3] = (dr * s + di * c + 2048) >>> 12;
    for (int i = 0; i < 4; i++) begin
      if (sc) v[i] = (v[i] + 1) >>> 1;
      if (v[i] > 32767)       begin v[i] = 32767;  clip = 1'b1; end
      else if (v[i] < -32768) begin v[i] = -32768; clip = 1'b1; end
      o[i] = v[i][15:0];
    end
    return {clip, o[0], o[1], o[2], o[3]};
  endfunction

  // Capture accepted pairs at the active edge
  always @(posedge clk) begin
    cyc++;
    clr_q = clr_sat;
    if (rst) exp_q.delete();
    else if (in_valid)
      exp_q.push_back({32'(cyc + 3), model(Re_i1, Im_i1, Re_i2, Im_i2, cos_data, sin_data, scale_en)});
  end

  // Compare outputs on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; exp_sat = 1'b0; last_data = '0;
      check("rst_data", {Re_X, Im_X, Re_Y, Im_Y}, 64'd0);
      check("rst_ctl", {out_valid, out_last, sat_flag}, 3'b000);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0][EW-1:65] == 32'(cyc));
      check("valid", out_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        last_data = e[63:0];
        check("last", out_last, (m_cnt == NP - 1));
        m_cnt = (m_cnt + 1) % NP;
        if (e[64])      exp_sat = 1'b1;
        else if (clr_q) exp_sat = 1'b0;
      end else begin
        check("last_idle", out_last, 1'b0);
        if (clr_q) exp_sat = 1'b0;
      end
      check("data", {Re_X, Im_X, Re_Y, Im_Y}, last_data);
      check("sat", sat_flag, exp_sat);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int a_re, a_im, b_re, b_im, c, s, input bit sc);
    @(posedge clk); #1;
    Re_i1 = 16'(a_re); Im_i1 = 16'(a_im); Re_i2 = 16'(b_re); Im_i2 = 16'(b_im);
    cos_data = 14'(c); sin_data = 14'(s); scale_en = sc;
    in_valid = 1'b1; clr_sat = 1'b0;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; clr_sat = clr;
      Re_i1 = 16'($urandom); Im_i1 = 16'($urandom);
    end
  endtask

  task automatic send_rand();
    int a_re, a_im, b_re, b_im;
    if ($urandom_range(0, 4) == 0) begin
      a_re = $urandom_range(30000, 32767); b_re = $urandom_range(30000, 32767);
    end else begin
      a_re = int'($urandom_range(0, 65535)) - 32768; b_re = int'($urandom_range(0, 65535)) - 32768;
    end
    a_im = int'($urandom_range(0, 65535)) - 32768;
    b_im = int'($urandom_range(0, 65535)) - 32768;
    send(a_re, a_im, b_re, b_im, int'($urandom_range(0, 8192)) - 4096,
         int'($urandom_range(0, 8192)) - 4096, 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 7) == 0) begin
      @(posedge clk); #1;
      in_valid = 1'b0; clr_sat = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; m_cnt = 0;
    exp_sat = 1'b0; last_data = '0; clr_q = 1'b0;
    rst = 1'b1; in_valid = 1'b0; scale_en = 1'b0; clr_sat = 1'b0;
    Re_i1 = '0; Im_i1 = '0; Re_i2 = '0; Im_i2 = '0; cos_data = '0; sin_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(1000, 200, 600, -100, 4096, 0, 1'b0);
    idle(5, 1'b0);
    check("tp1_x", {Re_X, Im_X}, {16'sd1600, 16'sd100});
    check("tp1_y", {Re_Y, Im_Y}, {16'sd400, 16'sd300});

    send(1000, 200, 600, -100, 0, 4096, 1'b0);
    idle(5, 1'b0);
    check("tp2_y", {Re_Y, Im_Y}, {-16'sd300, 16'sd400});

    send(1000, 200, 600, -100, 4096, 0, 1'b1);
    idle(5, 1'b0);
    check("tp3_x", {Re_X, Im_X}, {16'sd800, 16'sd50});
    check("tp3_y", {Re_Y, Im_Y}, {16'sd200, 16'sd150});

    send(3, 0, 0, 0, 2048, 0, 1'b0);
    idle(5, 1'b0);
    check("rnd_pos", Re_Y, 16'sd2);
    send(-3, 0, 0, 0, 2048, 0, 1'b0);
    idle(5, 1'b0);
    check("rnd_neg", Re_Y, -16'sd1);

    send(32767, 0, 32767, 0, 4096, 0, 1'b0);
    idle(5, 1'b0);
    check("sat_x", Re_X, 16'sd32767);
    check("sat_y", {Re_Y, Im_Y}, 32'd0);
    check("sat_flag_set", sat_flag, 1'b1);
    idle(4, 1'b0);
    check("sat_sticky", sat_flag, 1'b1);
    // New clip lands on the same edge as clr_sat
    send(32767, 0, 32767, 0, 4096, 0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    @(negedge clk);
    check("sat_set_wins", sat_flag, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("sat_cleared", sat_flag, 1'b0);

    // Frames with random gaps, then back-to-back pairs
    for (int i = 0; i < 12; i++) begin
      send(int'($urandom_range(0, 2000)), 5, 7, -9, 4096, 0, 1'b0);
      idle($urandom_range(0, 3), 1'b0);
    end
    for (int i = 0; i < 8; i++) send(i * 10, -i, i, 3, 2896, -2896, 1'b0);
    idle(6, 1'b0);

    // Reset with two pairs in flight
    send(100, 100, 1, 1, 4096, 0, 1'b0);
    send(200, 200, 2, 2, 4096, 0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4, 1'b0);
    send(50, 60, 10, 20, 4096, 0, 1'b0);
    idle(5, 1'b0);
    check("post_rst_x", {Re_X, Im_X}, {16'sd60, 16'sd80});

    for (int i = 0; i < 300; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end
    idle(8, 1'b0);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
